// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage core. It resolves load-use hazards,
// taken-branch redirects, instruction-memory wait states and debug halt/step.
// It also keeps a saturating count of the cycles in which the PC was held.
module pipeline_hazard_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MemRead_EX,
  input  logic [4:0]       RD_EX,
  input  logic [4:0]       RS1_ID,
  input  logic [4:0]       RS2_ID,
  input  logic             branch_taken_EX,
  input  logic             imem_ready,
  input  logic             debug_halt,
  input  logic             debug_step,
  output logic             PC_write,
  output logic             PCSrc,
  output logic             IF_ID_write,
  output logic             IF_ID_flush,
  output logic             ID_EX_bubble,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {RUN, LOAD_STALL, HALT, STEP} state_t;

  // The hazard cycle itself is the first stall cycle, so LOAD_STALL only has
  // to cover the remaining LOAD_STALL_CYCLES-1 cycles.
  localparam logic [3:0] LCNT_LOAD = 4'(LOAD_STALL_CYCLES - 1);

  state_t     state, state_nxt;
  logic [3:0] lcnt, lcnt_nxt;
  logic       step_pend, step_pend_nxt;
  logic       hazard;

  assign hazard = MemRead_EX && (RD_EX != 5'd0) &&
                  ((RD_EX == RS1_ID) || (RD_EX == RS2_ID));

  // Sequencing state registers.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      lcnt      <= 4'd0;
      step_pend <= 1'b0;
    end else begin
      state     <= state_nxt;
      lcnt      <= lcnt_nxt;
      step_pend <= step_pend_nxt;
    end
  end

  // Next-state and pipeline controls, decided by priority: redirect, then state.
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that skips
    // an assignment would otherwise infer a latch.
    state_nxt     = state;
    lcnt_nxt      = lcnt;
    step_pend_nxt = step_pend;
    PC_write      = 1'b0;
    PCSrc         = 1'b0;
    IF_ID_write   = 1'b0;
    IF_ID_flush   = 1'b0;
    ID_EX_bubble  = 1'b0;
    halted        = (state == HALT) || (state == STEP);

    if (branch_taken_EX) begin
      // A redirect is honoured in every state and cancels any pending sequence.
      PC_write      = 1'b1;
      PCSrc         = 1'b1;
      IF_ID_write   = 1'b1;
      IF_ID_flush   = 1'b1;
      ID_EX_bubble  = 1'b1;
      lcnt_nxt      = 4'd0;
      step_pend_nxt = 1'b0;
      state_nxt     = debug_halt ? HALT : RUN;
    end else begin
      case (state)
        RUN: begin
          if (hazard) begin
            ID_EX_bubble = 1'b1;
            lcnt_nxt     = LCNT_LOAD;
            state_nxt    = (LOAD_STALL_CYCLES > 1) ? LOAD_STALL : RUN;
          end else if (!imem_ready) begin
            // Fetch is not back yet: hold the PC, let ID advance, feed a NOP.
            IF_ID_write = 1'b1;
            IF_ID_flush = 1'b1;
          end else begin
            PC_write    = 1'b1;
            IF_ID_write = 1'b1;
            if (debug_halt) state_nxt = HALT;
          end
        end
        LOAD_STALL: begin
          ID_EX_bubble = 1'b1;
          // lcnt counts the stall cycles still owed including this one.
          if (lcnt <= 4'd1) begin
            lcnt_nxt  = 4'd0;
            state_nxt = debug_halt ? HALT : RUN;
          end else begin
            lcnt_nxt = lcnt - 4'd1;
          end
        end
        HALT: begin
          ID_EX_bubble = 1'b1;
          if (!debug_halt) begin
            state_nxt     = RUN;
            step_pend_nxt = 1'b0;
          end else if (step_pend && imem_ready) begin
            state_nxt     = STEP;
            step_pend_nxt = 1'b0;
          end else if (debug_step) begin
            // Only one step is remembered; further pulses while pending are lost.
            step_pend_nxt = 1'b1;
          end
        end
        STEP: begin
          PC_write    = 1'b1;
          IF_ID_write = 1'b1;
          state_nxt   = debug_halt ? HALT : RUN;
        end
        default: state_nxt = RUN;
      endcase
    end

    // While reset is held the front end is frozen and ID/EX is kept empty.
    if (!reset) begin
      PC_write     = 1'b0;
      PCSrc        = 1'b0;
      IF_ID_write  = 1'b0;
      IF_ID_flush  = 1'b1;
      ID_EX_bubble = 1'b1;
      halted       = 1'b0;
    end
  end

  // Saturating count of cycles in which the PC did not advance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
    end else if (!PC_write && (stall_count != {CNT_W{1'b1}})) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a cycle-by-cycle vector table on the
// default configuration plus hand-written multi-cycle sequences for the
// longer load-use stall, counter saturation and reset during a stall.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       mr, br, ir, dh, ds;
  logic [4:0] rd, rs1, rs2;

  // Default instance: LOAD_STALL_CYCLES=1, CNT_W=16.
  logic        pcw1, pcs1, ifw1, iff1, bub1, hlt1;
  logic [15:0] cnt1;
  // Three-cycle load-use stall.
  logic        pcw3, pcs3, ifw3, iff3, bub3, hlt3;
  logic [15:0] cnt3;
  // Narrow counter for saturation.
  logic        pcws, pcss, ifws, iffs, bubs, hlts;
  logic [3:0]  cnts;

  pipeline_hazard_ctrl dut1 (
    .clk(clk), .reset(reset), .MemRead_EX(mr), .RD_EX(rd), .RS1_ID(rs1),
    .RS2_ID(rs2), .branch_taken_EX(br), .imem_ready(ir), .debug_halt(dh),
    .debug_step(ds), .PC_write(pcw1), .PCSrc(pcs1), .IF_ID_write(ifw1),
    .IF_ID_flush(iff1), .ID_EX_bubble(bub1), .halted(hlt1), .stall_count(cnt1)
  );

  pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(3), .CNT_W(16)) dut3 (
    .clk(clk), .reset(reset), .MemRead_EX(mr), .RD_EX(rd), .RS1_ID(rs1),
    .RS2_ID(rs2), .branch_taken_EX(br), .imem_ready(ir), .debug_halt(dh),
    .debug_step(ds), .PC_write(pcw3), .PCSrc(pcs3), .IF_ID_write(ifw3),
    .IF_ID_flush(iff3), .ID_EX_bubble(bub3), .halted(hlt3), .stall_count(cnt3)
  );

  pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .MemRead_EX(mr), .RD_EX(rd), .RS1_ID(rs1),
    .RS2_ID(rs2), .branch_taken_EX(br), .imem_ready(ir), .debug_halt(dh),
    .debug_step(ds), .PC_write(pcws), .PCSrc(pcss), .IF_ID_write(ifws),
    .IF_ID_flush(iffs), .ID_EX_bubble(bubs), .halted(hlts), .stall_count(cnts)
  );

  always #5 clk = ~clk;

  // Output pattern order: {PC_write, PCSrc, IF_ID_write, IF_ID_flush, ID_EX_bubble, halted}
  localparam logic [5:0] O_NORM  = 6'b101000;
  localparam logic [5:0] O_STALL = 6'b000010;
  localparam logic [5:0] O_BR    = 6'b111110;
  localparam logic [5:0] O_BRH   = 6'b111111;
  localparam logic [5:0] O_WAIT  = 6'b001100;
  localparam logic [5:0] O_HALT  = 6'b000011;
  localparam logic [5:0] O_STEP  = 6'b101001;
  localparam logic [5:0] O_RST   = 6'b000110;

  typedef struct {
    logic       mr;
    logic [4:0] rd, rs1, rs2;
    logic       br, ir, dh, ds;
    logic [5:0] exp_out;
    int         exp_cnt;
  } vec_t;

  vec_t vq[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic m, input int d, input int s1, input int s2,
                     input logic b, input logic i, input logic h, input logic s,
                     input logic [5:0] eo, input int ec);
    vec_t v;
    v.mr = m; v.rd = 5'(d); v.rs1 = 5'(s1); v.rs2 = 5'(s2);
    v.br = b; v.ir = i; v.dh = h; v.ds = s;
    v.exp_out = eo; v.exp_cnt = ec;
    vq.push_back(v);
  endtask

  task automatic set_idle();
    mr = 1'b0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
    br = 1'b0; ir = 1'b1; dh = 1'b0; ds = 1'b0;
  endtask

  // Holds reset for two edges, checks the forced outputs, releases just after an edge.
  task automatic do_reset(input string tag);
    set_idle();
    reset = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check({tag, "_rst_out"}, 32'({pcw1, pcs1, ifw1, iff1, bub1, hlt1}), 32'(O_RST));
    check({tag, "_rst_cnt"}, 32'(cnt1), 32'd0);
    reset = 1'b1;
  endtask

  initial begin
    int stalls;

    // Vectors for dut1; exp_cnt is stall_count before the cycle's own edge.
    //   mr rd rs1 rs2 br ir dh ds  outputs  cnt
    add(0, 0, 0, 0, 0, 1, 0, 0, O_NORM,  0);   // 0 plain run
    add(1, 5, 5, 0, 0, 1, 0, 0, O_STALL, 0);   // 1 load-use on rs1
    add(0, 0, 0, 0, 0, 1, 0, 0, O_NORM,  1);   // 2 single stall done
    add(1, 0, 0, 0, 0, 1, 0, 0, O_NORM,  1);   // 3 rd=x0 never stalls
    add(1, 7, 3, 7, 0, 1, 0, 0, O_STALL, 1);   // 4 load-use on rs2
    add(0, 7, 7, 0, 0, 1, 0, 0, O_NORM,  2);   // 5 not a load
    add(1, 5, 5, 0, 1, 1, 0, 0, O_BR,    2);   // 6 branch beats hazard
    add(0, 0, 0, 0, 0, 1, 0, 0, O_NORM,  2);   // 7 no stall after branch
    add(0, 0, 0, 0, 0, 0, 0, 0, O_WAIT,  2);   // 8 imem wait x4
    add(0, 0, 0, 0, 0, 0, 0, 0, O_WAIT,  3);   // 9
    add(0, 0, 0, 0, 0, 0, 0, 0, O_WAIT,  4);   // 10
    add(0, 0, 0, 0, 0, 0, 0, 0, O_WAIT,  5);   // 11
    add(0, 0, 0, 0, 0, 1, 0, 0, O_NORM,  6);   // 12
    add(0, 0, 0, 0, 0, 1, 1, 0, O_NORM,  6);   // 13 halt request still advances
    add(0, 0, 0, 0, 0, 1, 1, 0, O_HALT,  6);   // 14 halted
    add(0, 0, 0, 0, 0, 0, 1, 1, O_HALT,  7);   // 15 step with imem not ready
    add(0, 0, 0, 0, 0, 0, 1, 1, O_HALT,  8);   // 16 extra pulse dropped
    add(0, 0, 0, 0, 0, 1, 1, 0, O_HALT,  9);   // 17 imem ready -> step next
    add(0, 0, 0, 0, 0, 1, 1, 0, O_STEP, 10);   // 18 the single step
    add(0, 0, 0, 0, 0, 1, 1, 0, O_HALT, 10);   // 19 back in halt
    add(0, 0, 0, 0, 0, 1, 0, 0, O_HALT, 11);   // 20 release halt
    add(0, 0, 0, 0, 0, 1, 0, 0, O_NORM, 12);   // 21 running
    add(0, 0, 0, 0, 1, 1, 1, 0, O_BR,   12);   // 22 branch with halt -> halt
    add(0, 0, 0, 0, 1, 1, 1, 0, O_BRH,  12);   // 23 branch honoured in halt
    add(0, 0, 0, 0, 0, 1, 0, 0, O_HALT, 12);   // 24 release
    add(0, 0, 0, 0, 0, 1, 0, 0, O_NORM, 13);   // 25 running

    do_reset("tbl");
    foreach (vq[i]) begin
      mr = vq[i].mr; rd = vq[i].rd; rs1 = vq[i].rs1; rs2 = vq[i].rs2;
      br = vq[i].br; ir = vq[i].ir; dh = vq[i].dh; ds = vq[i].ds;
      @(negedge clk);
      check($sformatf("vec%0d_out", i), 32'({pcw1, pcs1, ifw1, iff1, bub1, hlt1}),
            32'(vq[i].exp_out));
      check($sformatf("vec%0d_cnt", i), 32'(cnt1), 32'(vq[i].exp_cnt));
      @(posedge clk);
      #1;
    end

    // Three-cycle load-use stall on rs2, counted until the PC moves again.
    do_reset("ls3");
    mr = 1'b1; rd = 5'd5; rs2 = 5'd5;
    stalls = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (pcw3) break;
      stalls++;
      check("ls3_bub", 32'({ifw3, bub3}), 32'b01);
      @(posedge clk);
      #1;
      set_idle();
    end
    check("ls3_len", 32'(stalls), 32'd3);
    check("ls3_cnt", 32'(cnt3), 32'd3);
    @(posedge clk);
    #1;
    mr = 1'b1; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
    @(negedge clk);
    check("ls3_x0", 32'(pcw3), 32'd1);
    @(posedge clk);
    #1;

    // Halt requested at the hazard: halted only after the stall finishes.
    do_reset("lsh");
    mr = 1'b1; rd = 5'd9; rs1 = 5'd9; dh = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check($sformatf("lsh_c%0d", c), 32'(hlt3), (c == 4) ? 32'd1 : 32'd0);
      @(posedge clk);
      #1;
      mr = 1'b0;
    end
    dh = 1'b0;

    // Counter saturation: 20 wait cycles on the 4-bit counter.
    do_reset("sat");
    ir = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("sat_cnt4", 32'(cnts), 32'd15);
    check("sat_cnt16", 32'(cnt1), 32'd20);
    set_idle();

    // Asynchronous reset in the middle of a load-use stall.
    do_reset("rms");
    mr = 1'b1; rd = 5'd4; rs1 = 5'd4;
    @(posedge clk);
    #1;
    set_idle();
    @(negedge clk);
    check("rms_in_stall", 32'(pcw3), 32'd0);
    reset = 1'b0;
    #1;
    check("rms_out", 32'({pcw3, pcs3, ifw3, iff3, bub3, hlt3}), 32'(O_RST));
    check("rms_cnt", 32'(cnt3), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("rms_run", 32'({pcw3, pcs3, ifw3, iff3, bub3, hlt3}), 32'(O_NORM));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
